// File: rtl/pipelined_hybrid_adder_pkg.sv
// rtl/pipelined_hybrid_adder_pkg.sv - shared defaults and stage-count helpers for the pipelined adder family
package pipelined_hybrid_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK   = 4;

  function automatic bit params_ok(input int width, input int blk);
    if (blk < 1) return 1'b0;
    return (width % blk) == 0;
  endfunction

  function automatic int calc_nstg(input int width, input int blk);
    return (blk > 0) ? (width / blk) : 1;
  endfunction

endpackage

// File: rtl/pipelined_hybrid_adder_cla.sv
// rtl/pipelined_hybrid_adder_cla.sv - combinational BLK-bit carry-lookahead block
module cla_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] x,
  input  logic [BLK-1:0] y,
  input  logic           c_in,
  output logic [BLK-1:0] s,
  output logic           c_out,
  output logic           c_msb_in
);

  logic [BLK-1:0] w_g;
  logic [BLK-1:0] w_p;
  logic [BLK:0]   w_c;
  logic           w_term;

  // Each carry is a flat sum of generate terms, never a chain through lower carries.
  always_comb begin
    w_g    = x & y;
    w_p    = x ^ y;
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = c_in;
    for (int i = 0; i < BLK; i++) begin
      w_c[i+1] = w_g[i];
      w_term   = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_term & w_g[j]);
        w_term   = w_term & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | (w_term & c_in);
    end
  end

  assign s        = w_p ^ w_c[BLK-1:0];
  assign c_out    = w_c[BLK];
  assign c_msb_in = w_c[BLK-1];

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// rtl/pipelined_hybrid_adder.sv - pipelined add/subtract unit, one CLA block resolved per stage
module pipelined_hybrid_adder
  import pipelined_hybrid_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = calc_nstg(WIDTH, BLK);

  if (!params_ok(WIDTH, BLK)) begin : g_bad_params
    $error("pipelined_hybrid_adder: WIDTH=%0d must be a positive multiple of BLK=%0d", WIDTH, BLK);
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_b_x;
  logic             w_c_x;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;
  assign w_b_x     = b ^ {WIDTH{sub}};
  assign w_c_x     = sub | cin;

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    logic [BLK-1:0]       w_x;
    logic [BLK-1:0]       w_y;
    logic [BLK-1:0]       w_s;
    logic                 w_ci;
    logic                 w_vin;
    logic                 w_co;
    logic                 w_cmsb;
    logic [(k+1)*BLK-1:0] w_lo_nxt;
    logic                 r_valid;
    logic                 r_carry;
    logic [(k+1)*BLK-1:0] r_lo;

    if (k == 0) begin : g_src
      assign w_x      = a[BLK-1:0];
      assign w_y      = w_b_x[BLK-1:0];
      assign w_ci     = w_c_x;
      assign w_vin    = in_valid;
      assign w_lo_nxt = w_s;
    end else begin : g_src
      assign w_x      = g_stage[k-1].g_hi.r_hi_a[BLK-1:0];
      assign w_y      = g_stage[k-1].g_hi.r_hi_b[BLK-1:0];
      assign w_ci     = g_stage[k-1].r_carry;
      assign w_vin    = g_stage[k-1].r_valid;
      assign w_lo_nxt = {w_s, g_stage[k-1].r_lo};
    end

    cla_block #(.BLK(BLK)) u_cla (
      .x        (w_x),
      .y        (w_y),
      .c_in     (w_ci),
      .s        (w_s),
      .c_out    (w_co),
      .c_msb_in (w_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_lo    <= '0;
      end else if (w_advance) begin
        r_valid <= w_vin;
        r_carry <= w_co;
        r_lo    <= w_lo_nxt;
      end
    end

    // Operand bits not yet resolved travel alongside, shrinking by one block per stage.
    if (k < NSTG - 1) begin : g_hi
      localparam int RW = WIDTH - (k + 1) * BLK;
      logic [RW-1:0] w_hi_a;
      logic [RW-1:0] w_hi_b;
      logic [RW-1:0] r_hi_a;
      logic [RW-1:0] r_hi_b;

      if (k == 0) begin : g_ld
        assign w_hi_a = a[WIDTH-1:BLK];
        assign w_hi_b = w_b_x[WIDTH-1:BLK];
      end else begin : g_ld
        assign w_hi_a = g_stage[k-1].g_hi.r_hi_a[RW+BLK-1:BLK];
        assign w_hi_b = g_stage[k-1].g_hi.r_hi_b[RW+BLK-1:BLK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hi_a <= '0;
          r_hi_b <= '0;
        end else if (w_advance) begin
          r_hi_a <= w_hi_a;
          r_hi_b <= w_hi_b;
        end
      end
    end

    if (k == NSTG - 1) begin : g_last
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_co ^ w_cmsb;
        end
      end
    end
  end

  assign out_valid = g_stage[NSTG-1].r_valid;
  assign sum       = g_stage[NSTG-1].r_lo;
  assign cout      = g_stage[NSTG-1].r_carry;
  assign ovf       = g_stage[NSTG-1].g_last.r_ovf;

endmodule
